// File: rtl/ppm_slot_ctrl.sv
// rtl/ppm_slot_ctrl.sv - PPM symbol decoder: frame sync, slot timing, pulse capture.
// Optional build macro PPM_SYNC_EN adds a two-flop input synchronizer ahead of ppm_s.
module ppm_slot_ctrl #(
    parameter int SLOT_CYC  = 128,
    parameter int PPM_ORDER = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         run,
    input  logic                         ppm_in,
    output logic                         busy,
    output logic                         slot_tick,
    output logic                         sym_valid,
    output logic [$clog2(PPM_ORDER)-1:0] sym_data,
    output logic                         sym_err
);

    localparam int DW = $clog2(PPM_ORDER);
    localparam int CW = $clog2(SLOT_CYC);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARM   = 2'd1;
    localparam logic [1:0] S_SLOTS = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cyc_cnt;
    logic [DW-1:0] slot_idx;
    logic [DW-1:0] cap;
    logic          seen;
    logic          multi;
    logic          ppm_s;
    logic          ppm_d;
    logic          rise;

`ifdef PPM_SYNC_EN
    logic sync_meta;
    logic sync_q;

    // Two-flop synchronizer followed by the same output register as the plain build.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            ppm_s     <= 1'b0;
        end else begin
            sync_meta <= ppm_in;
            sync_q    <= sync_meta;
            ppm_s     <= sync_q;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ppm_s <= 1'b0;
        end else begin
            ppm_s <= ppm_in;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ppm_d <= 1'b0;
        end else begin
            ppm_d <= ppm_s;
        end
    end

    assign rise = ppm_s & ~ppm_d;

    logic in_slots;
    logic last_cyc;
    logic last_slot;

    assign in_slots  = (state == S_SLOTS);
    assign last_cyc  = (cyc_cnt == CW'(SLOT_CYC - 1));
    assign last_slot = (slot_idx == DW'(PPM_ORDER - 1));
    assign slot_tick = in_slots & last_cyc;
    assign sym_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    // Next-value view of the capture so a rise on the final cycle still lands in the symbol.
    logic          seen_n;
    logic          multi_n;
    logic [DW-1:0] cap_n;

    always_comb begin
        seen_n  = seen;
        multi_n = multi;
        cap_n   = cap;
        if (in_slots && rise) begin
            if (!seen) begin
                seen_n = 1'b1;
                cap_n  = slot_idx;
            end else begin
                multi_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cyc_cnt  <= '0;
            slot_idx <= '0;
            cap      <= '0;
            seen     <= 1'b0;
            multi    <= 1'b0;
            sym_data <= '0;
            sym_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (rise) begin
                        state    <= S_SLOTS;
                        cyc_cnt  <= '0;
                        slot_idx <= '0;
                        cap      <= '0;
                        seen     <= 1'b0;
                        multi    <= 1'b0;
                    end else if (!run) begin
                        state <= S_IDLE;
                    end
                end
                S_SLOTS: begin
                    seen  <= seen_n;
                    multi <= multi_n;
                    cap   <= cap_n;
                    if (last_cyc) begin
                        cyc_cnt <= '0;
                        if (last_slot) begin
                            state    <= S_DONE;
                            sym_data <= seen_n ? cap_n : '0;
                            sym_err  <= ~seen_n | multi_n;
                        end else begin
                            slot_idx <= slot_idx + DW'(1);
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= run ? S_ARM : S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ppm_slot_ctrl.sv
// tb/tb_ppm_slot_ctrl.sv - scoreboard bench for ppm_slot_ctrl with a slot-arithmetic reference model.
module tb_ppm_slot_ctrl;

    localparam int SLOT_CYC  = 128;
    localparam int PPM_ORDER = 16;
    localparam int FRAME     = SLOT_CYC * PPM_ORDER;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       ppm_in;
    logic       busy;
    logic       slot_tick;
    logic       sym_valid;
    logic [3:0] sym_data;
    logic       sym_err;

    ppm_slot_ctrl #(.SLOT_CYC(SLOT_CYC), .PPM_ORDER(PPM_ORDER)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .ppm_in    (ppm_in),
        .busy      (busy),
        .slot_tick (slot_tick),
        .sym_valid (sym_valid),
        .sym_data  (sym_data),
        .sym_err   (sym_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int data;
        int err;
        int at;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops an expected symbol whenever the DUT strobes one, and polices slot_tick spacing.
    int ticks   = 0;
    int last_tk = -1;
    always @(negedge clk) begin
        if (!rst_n) begin
            ticks   = 0;
            last_tk = -1;
        end else begin
            if (slot_tick) begin
                if (last_tk >= 0) chk("tick_gap", cyc - last_tk, SLOT_CYC);
                last_tk = cyc;
                ticks++;
            end
            if (sym_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_sym_valid", 1, 0);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    chk("sym_cycle", cyc, x.at);
                    chk("sym_data", int'(sym_data), x.data);
                    chk("sym_err", int'(sym_err), x.err);
                    chk("tick_count", ticks, PPM_ORDER);
                end
                ticks   = 0;
                last_tk = -1;
            end else if (exp_q.size() > 0 && cyc > exp_q[0].at) begin
                chk("sym_valid_missing", 0, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ppm_in goes high just after posedge p, giving a rise in cycle p+1.
    task automatic pulse_at(input int p);
        wait_cyc(p);
        ppm_in = 1'b1;
        wait_cyc(p + 2);
        ppm_in = 1'b0;
    endtask

    // One frame: sync at e, slot 0 starts at e+2, pulses at frame offsets o0/o1 (n of them).
    task automatic frame(input int n, input int o0, input int o1, input int drop_at);
        int   e;
        exp_t x;
        @(posedge clk);
        #1;
        e = cyc;
        if (n == 0) begin
            x.data = 0;
            x.err  = 1;
        end else begin
            x.data = o0 / SLOT_CYC;
            x.err  = (n > 1) ? 1 : 0;
        end
        x.at = e + 2 + FRAME;
        exp_q.push_back(x);
        pulse_at(e);
        if (drop_at >= 0) begin
            wait_cyc(e + 1 + drop_at);
            run = 1'b0;
        end
        if (n >= 1) pulse_at(e + 1 + o0);
        if (n >= 2) pulse_at(e + 1 + o1);
        wait_cyc(e + FRAME + 4);
        if (drop_at >= 0) chk("busy_after_drop", int'(busy), 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_slot_tick"}, int'(slot_tick), 0);
        chk({tag, "_sym_valid"}, int'(sym_valid), 0);
        chk({tag, "_sym_data"}, int'(sym_data), 0);
        chk({tag, "_sym_err"}, int'(sym_err), 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        run    = 1'b0;
        ppm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_without_run", int'(busy), 0);
        run = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("armed_busy", int'(busy), 1);

        frame(1, 5 * SLOT_CYC + 10, 0, -1);
        frame(0, 0, 0, -1);
        frame(2, 3 * SLOT_CYC + 20, 9 * SLOT_CYC + 40, -1);
        frame(1, 4 * SLOT_CYC - 1, 0, -1);
        frame(1, FRAME - 1, 0, -1);
        frame(2, 6 * SLOT_CYC, 6 * SLOT_CYC + 60, -1);

        for (int i = 0; i < 6; i++) begin
            int n;
            int o0;
            int o1;
            n  = $urandom_range(0, 2);
            o0 = $urandom_range(4, FRAME - 8);
            o1 = $urandom_range(o0 + 4, FRAME - 1);
            frame(n, o0, o1, -1);
        end

        frame(1, 12 * SLOT_CYC + 5, 0, 7 * SLOT_CYC + 3);
        pulse_at(cyc + 3);
        repeat (300) @(posedge clk);
        #1;
        chk("idle_ignores_rise", int'(busy), 0);
        run = 1'b1;
        repeat (3) @(posedge clk);

        // Reset in the middle of slot 4 discards the symbol.
        begin
            int e;
            @(posedge clk);
            #1;
            e = cyc;
            pulse_at(e);
            wait_cyc(e + 2 + 4 * SLOT_CYC + 20);
            rst_n = 1'b0;
            #1;
            chk_outputs_zero("midreset");
            repeat (3) @(posedge clk);
            #1;
            run   = 1'b0;
            rst_n = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            chk("post_reset_idle", int'(busy), 0);
            run = 1'b1;
            repeat (3) @(posedge clk);
        end

        frame(1, 10 * SLOT_CYC + 77, 0, -1);

        repeat (20) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
